regfile_write_arbiter: RTL

- Shares the single write port of the 8x16 register file among NUM_REQ writeback requesters, e.g. ALU result, load data and stack-pointer (R6) update.
- Round-robin arbitration with a valid/ready handshake per requester.
- The winner is registered into one output stage that drives write_enable, write_destination and write_data of the register file.
- Sits between the execute/memory writeback sources and the register file.

---
 rtl/regfile_write_arbiter_if.sv | 26 ++
 rtl/regfile_write_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester handshake bundle for regfile_write_arbiter.
// Packed per-requester destinations and data, one-hot ready back.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_dest;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_dest,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dest,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port, registered output.
// Optional decode bypass hit outputs under macro RF_WRITE_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    regfile_write_arbiter_if.slave req,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_destination,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [15:0]       write_count
`ifdef RF_WRITE_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] byp_addr_1,
    input  logic [ADDR_W-1:0] byp_addr_2,
    output logic              byp_hit_1,
    output logic              byp_hit_2
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);

    logic [PW-1:0]      last_grant;
    logic [PW-1:0]      win;
    logic [NUM_REQ-1:0] grant;
    logic               gnt;
    logic [ADDR_W-1:0]  win_dest;
    logic [DATA_W-1:0]  win_data;

    // Search starts one past the previous winner and wraps.
    always_comb begin
        int          idx;
        logic [PW-1:0] cand;
        logic        found;
        grant = '0;
        win   = last_grant;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(last_grant) + k) % NUM_REQ;
            cand = PW'(idx);
            if (!found && req.req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                win         = cand;
            end
        end
        if (hold || !rst) begin
            grant = '0;
        end
    end

    assign gnt           = |grant;
    assign req.req_ready = grant;

    always_comb begin
        win_dest = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_dest = req.req_dest[i*ADDR_W +: ADDR_W];
                win_data = req.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant           <= PTR_RST;
            rf_write_enable      <= 1'b0;
            rf_write_destination <= '0;
            rf_write_data        <= '0;
            write_count          <= '0;
        end else begin
            if (gnt) begin
                last_grant           <= win;
                rf_write_enable      <= 1'b1;
                rf_write_destination <= win_dest;
                rf_write_data        <= win_data;
            end else begin
                rf_write_enable <= 1'b0;
            end
            if (rf_write_enable) begin
                write_count <= write_count + 16'd1;
            end
        end
    end

`ifdef RF_WRITE_BYPASS_EN
    assign byp_hit_1 = rst && rf_write_enable &&
                       (rf_write_destination == byp_addr_1);
    assign byp_hit_2 = rst && rf_write_enable &&
                       (rf_write_destination == byp_addr_2);
`endif

endmodule
